// File: rtl/solo_squash_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// solo_squash_input_conditioner_if : pad/strobe bundle of the input conditioner
// Revision 1.0
// ============================================================================
interface solo_squash_input_conditioner_if #(
  parameter int NUM_INPUTS = 4
);
  logic                  gpio_ready;
  logic [NUM_INPUTS-1:0] btn_n_in;
  logic [NUM_INPUTS-1:0] btn_n_out;
  logic [NUM_INPUTS-1:0] press_pulse;
  logic [NUM_INPUTS-1:0] release_pulse;

  modport master (
    output gpio_ready,
    output btn_n_in,
    input  btn_n_out,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  gpio_ready,
    input  btn_n_in,
    output btn_n_out,
    output press_pulse,
    output release_pulse
  );
endinterface
`default_nettype wire

// File: rtl/solo_squash_input_conditioner.sv
`default_nettype none
// ============================================================================
// solo_squash_input_conditioner : sync, gate, debounce and strobe active-low pads
// Optional auto-repeat on REPEAT_MASK channels: SOLO_SQUASH_INPUT_REPEAT_EN
// Revision 1.0
// ============================================================================
module solo_squash_input_conditioner #(
  parameter int                    NUM_INPUTS      = 4,
  parameter int                    DEBOUNCE_CYCLES = 250000,
  parameter logic [NUM_INPUTS-1:0] REPEAT_MASK     = 4'b1100,
  parameter int                    REPEAT_DELAY    = 6250000,
  parameter int                    REPEAT_PERIOD   = 1250000
) (
  input  wire logic                      wb_clk_i,
  input  wire logic                      reset_n,
  solo_squash_input_conditioner_if.slave bus
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_INPUTS-1:0] sync1;
  logic [NUM_INPUTS-1:0] sync2;
  logic [NUM_INPUTS-1:0] eff;

  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.btn_n_in;
      sync2 <= sync1;
    end
  end

  // Unconfigured GPIOs read as released on every channel.
  assign eff = bus.gpio_ready ? sync2 : {NUM_INPUTS{1'b1}};

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             press_q;
    logic             release_q;
    logic             commit;
    logic             rep_fire;

    assign commit = (eff[i] != level) && (cnt == CNT_MAX);

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
        cnt       <= '0;
        level     <= 1'b1;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= (commit && !eff[i]) || rep_fire;
        release_q <= commit && eff[i];
        if (eff[i] == level) begin
          cnt <= '0;
        end else if (commit) begin
          cnt   <= '0;
          level <= eff[i];
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

`ifdef SOLO_SQUASH_INPUT_REPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      localparam int               REP_W     = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
      localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
      localparam logic [REP_W-1:0] REP_WRAP  = REP_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);

      logic [REP_W-1:0] rep_cnt;

      // After the first repeat the counter loops over the last REPEAT_PERIOD values.
      always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
          rep_cnt <= '0;
        end else if (commit || level) begin
          rep_cnt <= '0;
        end else if (rep_cnt == REP_WRAP) begin
          rep_cnt <= REP_W'(REPEAT_DELAY);
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
      end

      assign rep_fire = !level && !commit && ((rep_cnt == REP_FIRST) || (rep_cnt == REP_WRAP));
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign bus.btn_n_out[i]     = level;
    assign bus.press_pulse[i]   = press_q;
    assign bus.release_pulse[i] = release_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_solo_squash_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_solo_squash_input_conditioner : directed scoreboard bench for the conditioner
// Revision 1.0
// ============================================================================
module tb_solo_squash_input_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RPER = 3;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  sb[$];
  logic [3:0] exp_level = 4'hF;
  logic [3:0] ep;
  logic [3:0] er;
  int   n;
  int   t0;

  solo_squash_input_conditioner_if #(.NUM_INPUTS(4)) bus ();

  solo_squash_input_conditioner #(
    .NUM_INPUTS     (4),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_MASK    (4'b1100),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .wb_clk_i(clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [3:0] p, input logic [3:0] r);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    sb.push_back(e);
  endtask

  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Scoreboard: pop events due this cycle and compare strobes and levels.
  always @(negedge clk) begin
    ep = 4'h0;
    er = 4'h0;
    if (!reset_n) begin
      exp_level = 4'hF;
    end else begin
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].cyc == cyc) begin
          ep |= sb[k].press;
          er |= sb[k].rel;
          sb.delete(k);
        end
      end
    end
    exp_level = (exp_level & ~ep) | er;
    check("press_pulse", bus.press_pulse, ep);
    check("release_pulse", bus.release_pulse, er);
    check("btn_n_out", bus.btn_n_out, exp_level);
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with all pads pressed.
    reset_n        = 1'b0;
    bus.btn_n_in   = 4'b0000;
    bus.gpio_ready = 1'b1;
    wait_cycles(4);
    check("reset_level", bus.btn_n_out, 4'hF);
    check("reset_press", bus.press_pulse, 4'h0);
    bus.btn_n_in = 4'b1111;
    reset_n      = 1'b1;
    wait_cycles(8);

    // Clean press and release on bit2.
    bus.btn_n_in[2] = 1'b0;
    n = cyc;
    expect_ev(n + 2 + DEB, 4'b0100, 4'b0000);
    wait_cycles(8);
    bus.btn_n_in[2] = 1'b1;
    n = cyc;
    expect_ev(n + 2 + DEB, 4'b0000, 4'b0100);
    wait_cycles(10);

    // Bounce on bit3 never settles long enough.
    bus.btn_n_in[3] = 1'b0;
    wait_cycles(3);
    bus.btn_n_in[3] = 1'b1;
    wait_cycles(1);
    bus.btn_n_in[3] = 1'b0;
    wait_cycles(3);
    bus.btn_n_in[3] = 1'b1;
    wait_cycles(10);
    check("bounce_level", bus.btn_n_out, 4'hF);

    // Gating by gpio_ready, then release on gpio_ready falling.
    bus.gpio_ready = 1'b0;
    bus.btn_n_in   = 4'b0000;
    wait_cycles(20);
    check("gated_level", bus.btn_n_out, 4'hF);
    bus.gpio_ready = 1'b1;
    n = cyc;
    expect_ev(n + DEB, 4'b1111, 4'b0000);
    wait_cycles(6);
    bus.gpio_ready = 1'b0;
    expect_ev(n + 6 + DEB, 4'b0000, 4'b1111);
    wait_cycles(6);
    bus.btn_n_in = 4'b1111;
    wait_cycles(4);
    bus.gpio_ready = 1'b1;
    wait_cycles(6);

    // Reset while bit0 debounce count is 2.
    bus.btn_n_in[0] = 1'b0;
    wait_cycles(4);
    reset_n = 1'b0;
    wait_cycles(1);
    reset_n = 1'b1;
    n = cyc;
    expect_ev(n + 2 + DEB, 4'b0001, 4'b0000);
    wait_cycles(5);
    check("reset_restart_level", bus.btn_n_out, 4'hF);
    wait_cycles(5);
    bus.btn_n_in[0] = 1'b1;
    n = cyc;
    expect_ev(n + 2 + DEB, 4'b0000, 4'b0001);
    wait_cycles(10);

    // Hold bit3 and bit0; release lands exactly on a repeat slot of bit3.
    bus.btn_n_in = 4'b0110;
    n  = cyc;
    t0 = n + 2 + DEB;
    expect_ev(t0, 4'b1001, 4'b0000);
`ifdef SOLO_SQUASH_INPUT_REPEAT_EN
    expect_ev(t0 + RDLY, 4'b1000, 4'b0000);
    expect_ev(t0 + RDLY + RPER, 4'b1000, 4'b0000);
    expect_ev(t0 + RDLY + 2 * RPER, 4'b1000, 4'b0000);
`endif
    wait_cycles(RDLY + 3 * RPER);
    bus.btn_n_in = 4'b1111;
    expect_ev(t0 + RDLY + 3 * RPER, 4'b0000, 4'b1001);
    wait_cycles(12);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drained observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
